vga_sync_decoder: RTL and testbench

- Sits directly downstream of the horizontal and vertical pixel counters and consumes their h_count/v_count values.
- Decodes the counts into registered VGA hsync/vsync, a video_active blanking flag, pixel coordinates, line and frame strobes, and a frame counter.
- Tracks horizontal and vertical timing phases with FSMs and flags count sequences that violate the configured timing.
- Feeds the VGA pins and the pixel/sprite generation logic.

---
 rtl/vga_sync_decoder.sv | 146 ++++++++++++++
 tb/tb_vga_sync_decoder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: turns free-running h/v pixel counts into registered VGA
// sync, blanking, coordinates and frame strobes. Two small phase trackers
// check that the counts walk the configured timing and report a lock status.
`timescale 1ns/1ps

module vga_sync_decoder #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic       pixel_clk,
    input  logic       reset_n,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    output logic       hsync,
    output logic       vsync,
    output logic       video_active,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count,
    output logic       locked,
    output logic       timing_error
);

    // Last count of each phase on each axis
    localparam logic [9:0] H_A_END = 10'(H_DISPLAY - 1);
    localparam logic [9:0] H_F_END = 10'(H_DISPLAY + H_FRONT - 1);
    localparam logic [9:0] H_S_END = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] H_MAX   = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_A_END = 10'(V_DISPLAY - 1);
    localparam logic [9:0] V_F_END = 10'(V_DISPLAY + V_FRONT - 1);
    localparam logic [9:0] V_S_END = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] V_MAX   = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);

    // INVALID is only a decode result; the trackers never hold it
    typedef enum logic [2:0] {
        UNSYNC  = 3'd0,
        ACTIVE  = 3'd1,
        FRONT   = 3'd2,
        SYNC    = 3'd3,
        BACK    = 3'd4,
        INVALID = 3'd5
    } phase_e;

    function automatic phase_e decode(input logic [9:0] c, input logic [9:0] a_end,
                                      input logic [9:0] f_end, input logic [9:0] s_end,
                                      input logic [9:0] mx);
        if (c > mx)          return INVALID;
        else if (c <= a_end) return ACTIVE;
        else if (c <= f_end) return FRONT;
        else if (c <= s_end) return SYNC;
        else                 return BACK;
    endfunction

    // Same phase or the cyclic next one; anything valid is fine out of UNSYNC.
    // Holding a phase covers the vertical axis sitting on one line for a whole line.
    function automatic logic legal(input phase_e cur, input phase_e nxt);
        logic ok;
        ok = 1'b0;
        if (nxt == INVALID)   ok = 1'b0;
        else if (cur == UNSYNC || nxt == cur) ok = 1'b1;
        else begin
            case (cur)
                ACTIVE:  ok = (nxt == FRONT);
                FRONT:   ok = (nxt == SYNC);
                SYNC:    ok = (nxt == BACK);
                BACK:    ok = (nxt == ACTIVE);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    phase_e     h_st_q, v_st_q, h_st_d, v_st_d, h_ph, v_ph;
    logic       h0_q, org_q, h0_d, org_d;
    logic       bad, fs_d, ls_d, va_d, hs_d, vs_d, lock_d, terr_d;
    logic [9:0] x_d, y_d;
    logic [7:0] fc_d;

    // Decode this sample and work out every next-state value
    always_comb begin
        h_ph   = decode(h_count, H_A_END, H_F_END, H_S_END, H_MAX);
        v_ph   = decode(v_count, V_A_END, V_F_END, V_S_END, V_MAX);
        h_st_d = (h_ph == INVALID) ? UNSYNC : h_ph;
        v_st_d = (v_ph == INVALID) ? UNSYNC : v_ph;
        bad    = ~(legal(h_st_q, h_ph) & legal(v_st_q, v_ph));
        h0_d   = (h_count == 10'd0);
        org_d  = h0_d & (v_count == 10'd0);
        // strobes fire on the first sample of a held count only
        ls_d   = h0_d & ~h0_q;
        fs_d   = org_d & ~org_q;
        fc_d   = frame_count + 8'(fs_d);
        terr_d = locked & bad;
        // an erroneous sample can neither keep nor acquire lock
        lock_d = ~bad & (locked | fs_d);
        va_d   = (h_ph == ACTIVE) & (v_ph == ACTIVE);
        hs_d   = (h_ph == SYNC) ? SYNC_POL : ~SYNC_POL;
        vs_d   = (v_ph == SYNC) ? SYNC_POL : ~SYNC_POL;
        x_d    = va_d ? h_count : 10'd0;
        y_d    = va_d ? v_count : 10'd0;
    end

    // Phase trackers and all registered outputs
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            h_st_q       <= UNSYNC;
            v_st_q       <= UNSYNC;
            h0_q         <= 1'b0;
            org_q        <= 1'b0;
            hsync        <= ~SYNC_POL;
            vsync        <= ~SYNC_POL;
            video_active <= 1'b0;
            x_pos        <= 10'd0;
            y_pos        <= 10'd0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            frame_count  <= 8'd0;
            locked       <= 1'b0;
            timing_error <= 1'b0;
        end else begin
            h_st_q       <= h_st_d;
            v_st_q       <= v_st_d;
            h0_q         <= h0_d;
            org_q        <= org_d;
            hsync        <= hs_d;
            vsync        <= vs_d;
            video_active <= va_d;
            x_pos        <= x_d;
            y_pos        <= y_d;
            line_start   <= ls_d;
            frame_start  <= fs_d;
            frame_count  <= fc_d;
            locked       <= lock_d;
            timing_error <= terr_d;
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder. Frames are walked with compressed
// count sequences (phase boundaries only) so hundreds of frames fit in a
// short run, plus one full 800-pixel line for exact sync/active widths.
`timescale 1ns/1ps

module tb_vga_sync_decoder;

    logic       pixel_clk = 1'b0;
    logic       reset_n   = 1'b0;
    logic [9:0] h_count   = '0;
    logic [9:0] v_count   = '0;
    logic       hsync, vsync, video_active, line_start, frame_start, locked, timing_error;
    logic [9:0] x_pos, y_pos;
    logic [7:0] frame_count;

    vga_sync_decoder dut (
        .pixel_clk(pixel_clk), .reset_n(reset_n), .h_count(h_count), .v_count(v_count),
        .hsync(hsync), .vsync(vsync), .video_active(video_active), .x_pos(x_pos),
        .y_pos(y_pos), .line_start(line_start), .frame_start(frame_start),
        .frame_count(frame_count), .locked(locked), .timing_error(timing_error)
    );

    always #5 pixel_clk = ~pixel_clk;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // boundary samples of each phase, walked in order
    int hl[8] = '{0, 639, 640, 655, 656, 751, 752, 799};
    int vl[9] = '{0, 100, 479, 480, 489, 490, 491, 492, 524};

    // running statistics, cleared between scenarios
    int hs_bad, vs_bad, va_bad, xy_bad, fs_bad, ls_bad;
    int fs_cnt, ls_cnt, te_cnt, hs_low, first_low, va_cnt, vs_low;
    bit prev_h0 = 0, prev_org = 0;

    task automatic clear_stats();
        hs_bad = 0; vs_bad = 0; va_bad = 0; xy_bad = 0; fs_bad = 0; ls_bad = 0;
        fs_cnt = 0; ls_cnt = 0; te_cnt = 0; hs_low = 0; first_low = -1; va_cnt = 0; vs_low = 0;
    endtask

    // Present one sample, then look at the outputs it produced one edge later
    task automatic tick(input int h, input int v);
        bit e_hs, e_vs, e_va, e_ls, e_fs;
        h_count = 10'(h);
        v_count = 10'(v);
        @(posedge pixel_clk);
        #1;
        if (reset_n) begin
            e_hs = !(h >= 656 && h <= 751);
            e_vs = !(v >= 490 && v <= 491);
            e_va = (h < 640) && (v < 480);
            e_ls = (h == 0) && !prev_h0;
            e_fs = (h == 0) && (v == 0) && !prev_org;
            if (hsync !== e_hs) hs_bad++;
            if (vsync !== e_vs) vs_bad++;
            if (video_active !== e_va) va_bad++;
            if (x_pos !== (e_va ? 10'(h) : 10'd0) || y_pos !== (e_va ? 10'(v) : 10'd0)) xy_bad++;
            if (line_start !== e_ls) ls_bad++;
            if (frame_start !== e_fs) fs_bad++;
            if (hsync === 1'b0) begin
                if (first_low < 0) first_low = h;
                hs_low++;
            end
            if (vsync === 1'b0) vs_low++;
            if (video_active === 1'b1) va_cnt++;
            if (frame_start === 1'b1) fs_cnt++;
            if (line_start === 1'b1) ls_cnt++;
            if (timing_error === 1'b1) te_cnt++;
            prev_h0  = (h == 0);
            prev_org = (h == 0) && (v == 0);
        end else begin
            prev_h0  = 0;
            prev_org = 0;
        end
    endtask

    task automatic run_line(input int v, input bit full);
        if (full) for (int h = 0; h < 800; h++) tick(h, v);
        else      for (int i = 0; i < 8; i++) tick(hl[i], v);
    endtask

    task automatic run_frame();
        for (int i = 0; i < 9; i++) run_line(vl[i], 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_stats();
        // reset held from time zero
        repeat (3) tick(0, 0);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_va", video_active, 0);
        chk("rst_x", x_pos, 0);
        chk("rst_y", y_pos, 0);
        chk("rst_ls", line_start, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_fc", frame_count, 0);
        chk("rst_locked", locked, 0);
        chk("rst_terr", timing_error, 0);
        reset_n = 1'b1;

        // three legal frames
        clear_stats();
        repeat (3) run_frame();
        chk("f3_fs_cnt", fs_cnt, 3);
        chk("f3_fs_shape", fs_bad, 0);
        chk("f3_ls_cnt", ls_cnt, 27);
        chk("f3_ls_shape", ls_bad, 0);
        chk("f3_fc", frame_count, 3);
        chk("f3_locked", locked, 1);
        chk("f3_terr", te_cnt, 0);
        chk("f3_hs", hs_bad, 0);
        chk("f3_vs", vs_bad, 0);
        chk("f3_vs_low", vs_low, 48);
        chk("f3_va", va_bad, 0);
        chk("f3_xy", xy_bad, 0);

        // frame with one full-length visible line
        run_line(0, 1'b0);
        clear_stats();
        run_line(100, 1'b1);
        chk("full_hs_low", hs_low, 96);
        chk("full_hs_first", first_low, 656);
        chk("full_va_cnt", va_cnt, 640);
        chk("full_hs", hs_bad, 0);
        chk("full_xy", xy_bad, 0);
        chk("full_vs_low", vs_low, 0);
        for (int i = 2; i < 9; i++) run_line(vl[i], 1'b0);
        chk("f4_fc", frame_count, 4);

        // frame counter wrap
        clear_stats();
        repeat (251) run_frame();
        chk("wrap_fc255", frame_count, 255);
        run_frame();
        chk("wrap_fc0", frame_count, 0);
        chk("wrap_locked", locked, 1);
        chk("wrap_terr", te_cnt, 0);
        chk("wrap_fs_shape", fs_bad, 0);

        // illegal horizontal jump while locked
        clear_stats();
        tick(0, 0);
        tick(100, 0);
        tick(700, 0);
        chk("jump_terr", timing_error, 1);
        chk("jump_locked", locked, 0);
        tick(701, 0);
        chk("jump_terr_1cyc", timing_error, 0);
        tick(799, 0);
        chk("jump_still_unlocked", locked, 0);
        run_frame();
        chk("relock", locked, 1);
        chk("jump_terr_cnt", te_cnt, 1);

        // out-of-range count
        tick(0, 0);
        tick(639, 0);
        chk("pre_inv_va", video_active, 1);
        tick(900, 0);
        chk("inv_va", video_active, 0);
        chk("inv_x", x_pos, 0);
        chk("inv_hsync", hsync, 1);
        chk("inv_terr", timing_error, 1);
        chk("inv_locked", locked, 0);
        tick(700, 0);
        chk("unsync_hsync", hsync, 0);
        tick(900, 0);
        chk("inv2_hsync", hsync, 1);
        chk("inv2_terr", timing_error, 0);

        // held origin sample
        clear_stats();
        repeat (3) tick(0, 0);
        chk("held_fs_cnt", fs_cnt, 1);
        chk("held_ls_cnt", ls_cnt, 1);
        chk("held_locked", locked, 1);
        chk("held_fs_shape", fs_bad, 0);

        // asynchronous reset in the middle of a line
        tick(700, 300);
        chk("mid_pre_hsync", hsync, 0);
        chk("mid_pre_terr", timing_error, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_hsync", hsync, 1);
        chk("mid_terr", timing_error, 0);
        chk("mid_fc", frame_count, 0);
        chk("mid_locked", locked, 0);
        tick(0, 0);
        reset_n = 1'b1;
        tick(0, 0);
        chk("post_fs", frame_start, 1);
        chk("post_locked", locked, 1);
        chk("post_fc", frame_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
